// File: rtl/btn_event_gen_if.sv
// Signal bundle between one debounced button level and its event generator.
// The master drives the button level; the slave returns the registered events.
interface btn_event_gen_if;
  logic btnIn;
  logic pressPulse;
  logic releasePulse;
  logic longPulse;
  logic repeatPulse;
  logic held;

  modport master (
    output btnIn,
    input  pressPulse, releasePulse, longPulse, repeatPulse, held
  );

  modport slave (
    input  btnIn,
    output pressPulse, releasePulse, longPulse, repeatPulse, held
  );
endinterface

// File: rtl/btn_event_gen.sv
// Converts one debounced button level into registered one-cycle press/release/long/repeat
// events plus a held level. One instance per button; btnIn is already synchronous to clk.
module btn_event_gen #(
  parameter int   CLKIN_FREQ    = 27_000_000,
  parameter logic IDLE_STATE    = 1'b1,
  parameter int   LONG_PRESS_MS = 500,
  parameter int   REPEAT_MS     = 100
) (
  input  logic            clk,
  input  logic            reset,
  btn_event_gen_if.slave  bus
);
  localparam int LONG_CYCLES   = CLKIN_FREQ / 1000 * LONG_PRESS_MS;
  localparam int REPEAT_CYCLES = CLKIN_FREQ / 1000 * REPEAT_MS;
  localparam int MAX_CYCLES    = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CW            = $clog2(MAX_CYCLES + 1);
  localparam bit REP_EN        = (REPEAT_CYCLES > 0);
  localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_TC  = CW'(REP_EN ? REPEAT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          rep_q, rep_d;
  logic          held_q, held_d;
  logic          active;

  assign active = (bus.btnIn != IDLE_STATE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
    end
  end

  // Release is tested first in each held state so it beats a coincident terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    held_d  = held_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (active) begin
          state_d = PRESSED;
          press_d = 1'b1;
          held_d  = 1'b1;
        end
      end
      PRESSED: begin
        if (!active) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          held_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == LONG_TC) begin
          state_d = LONG;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LONG: begin
        if (!active) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          held_d  = 1'b0;
          cnt_d   = '0;
        end else if (!REP_EN) begin
          cnt_d = '0;
        end else if (cnt_q == REP_TC) begin
          rep_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase
  end

  assign bus.pressPulse   = press_q;
  assign bus.releasePulse = rel_q;
  assign bus.longPulse    = long_q;
  assign bus.repeatPulse  = rep_q;
  assign bus.held         = held_q;
endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen: 1 ms = 1 cycle, long press 5 cycles, repeat 2 cycles
// (second instance with repeat disabled). Edge numbers count posedges after reset release.
module tb_btn_event_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  btn_event_gen_if b1 ();
  btn_event_gen_if b2 ();

  btn_event_gen #(.CLKIN_FREQ(1000), .IDLE_STATE(1'b1), .LONG_PRESS_MS(5), .REPEAT_MS(2))
    dut_rep (.clk(clk), .reset(reset), .bus(b1));
  btn_event_gen #(.CLKIN_FREQ(1000), .IDLE_STATE(1'b1), .LONG_PRESS_MS(5), .REPEAT_MS(0))
    dut_norep (.clk(clk), .reset(reset), .bus(b2));

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {press, release, long, repeat, held}
  function automatic logic [4:0] outs(input int sel);
    if (sel == 0) return {b1.pressPulse, b1.releasePulse, b1.longPulse, b1.repeatPulse, b1.held};
    return {b2.pressPulse, b2.releasePulse, b2.longPulse, b2.repeatPulse, b2.held};
  endfunction

  function automatic logic [63:0] bits(input int a, input int b);
    logic [63:0] m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk_all0(input string tag, input int sel);
    logic [4:0] o = outs(sel);
    chk({tag, ".press"},   o[4], 1'b0);
    chk({tag, ".release"}, o[3], 1'b0);
    chk({tag, ".long"},    o[2], 1'b0);
    chk({tag, ".repeat"},  o[1], 1'b0);
    chk({tag, ".held"},    o[0], 1'b0);
  endtask

  task automatic do_reset(input string name);
    b1.btnIn = 1'b1;
    b2.btnIn = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk_all0({name, ".rst0"}, 0);
    chk_all0({name, ".rst1"}, 1);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // btnIn is sampled 0 on edges lo..hi-1 and 1 elsewhere; masks give the expected edges.
  task automatic run_case(input string name, input int sel, input int lo, input int hi,
                          input int n_edges, input logic [63:0] m_press, input logic [63:0] m_rel,
                          input logic [63:0] m_long, input logic [63:0] m_rep,
                          input logic [63:0] m_held);
    logic [4:0] o;
    do_reset(name);
    for (int e = 1; e <= n_edges; e++) begin
      b1.btnIn = (e >= lo && e < hi) ? 1'b0 : 1'b1;
      b2.btnIn = b1.btnIn;
      tick();
      o = outs(sel);
      chk($sformatf("%s.press@%0d", name, e),   o[4], m_press[e]);
      chk($sformatf("%s.release@%0d", name, e), o[3], m_rel[e]);
      chk($sformatf("%s.long@%0d", name, e),    o[2], m_long[e]);
      chk($sformatf("%s.repeat@%0d", name, e),  o[1], m_rep[e]);
      chk($sformatf("%s.held@%0d", name, e),    o[0], m_held[e]);
    end
  endtask

  initial begin
    logic [4:0] o;
    b1.btnIn = 1'b1;
    b2.btnIn = 1'b1;

    // idle level held throughout: nothing fires
    run_case("t1_idle", 0, 99, 99, 20, '0, '0, '0, '0, '0);
    // short press 10..12
    run_case("t2_short", 0, 10, 13, 20, bits(10, 10), bits(13, 13), '0, '0, bits(10, 12));
    // long press with repeats, release at 20
    run_case("t3_long", 0, 10, 20, 26, bits(10, 10), bits(20, 20), bits(15, 15),
             bits(17, 17) | bits(19, 19), bits(10, 19));
    // release coincides with long terminal count
    run_case("t4_race", 0, 10, 15, 20, bits(10, 10), bits(15, 15), '0, '0, bits(10, 14));
    // repeat disabled: one long pulse, no repeats
    run_case("t6_norep", 1, 10, 40, 45, bits(10, 10), bits(40, 40), bits(15, 15), '0,
             bits(10, 39));

    // async reset mid-hold at cycle 16.5, button still pressed afterwards
    do_reset("t5");
    for (int e = 1; e <= 16; e++) begin
      b1.btnIn = (e >= 10) ? 1'b0 : 1'b1;
      b2.btnIn = b1.btnIn;
      tick();
    end
    o = outs(0);
    chk("t5.held_before", o[0], 1'b1);
    #4 reset = 1'b1;
    #1;
    chk_all0("t5.async", 0);
    tick();
    chk_all0("t5.inrst", 0);
    reset = 1'b0;
    tick();
    o = outs(0);
    chk("t5.press_first", o[4], 1'b1);
    chk("t5.no_release",  o[3], 1'b0);
    chk("t5.held_first",  o[0], 1'b1);
    tick();
    o = outs(0);
    chk("t5.press_once",  o[4], 1'b0);
    chk("t5.no_release2", o[3], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
